// File: rtl/sprite_compositor_if.sv
// sprite_compositor_if
// Bundles everything between the sprite compositor and its surroundings except
// clock and reset:
//   pixel stream   : draw_x, draw_y, blank (0 = blanking), frame_start
//   attribute write: spr_wr_en/sel/x/y/w/h/scale/enable (shadow bank)
//   palette write  : pal_wr_en, pal_wr_idx, pal_wr_rgb; plus bg_rgb
//   sprite ROMs    : rom_addr (slice k = sprite k), rom_data (combinational
//                    read of rom_addr, consumed one cycle after the pixel)
//   results        : red, green, blue, collision
// master = the side feeding pixels and serving the ROMs, slave = compositor.
interface sprite_compositor_if #(
  parameter int NUM_SPRITES = 4,
  parameter int COORD_W     = 10,
  parameter int PIX_W       = 3,
  parameter int ADDR_W      = 13,
  parameter int SIZE_W      = 7
);
  localparam int SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  logic [COORD_W-1:0]            draw_x;
  logic [COORD_W-1:0]            draw_y;
  logic                          blank;
  logic                          frame_start;
  logic                          spr_wr_en;
  logic [SEL_W-1:0]              spr_wr_sel;
  logic [COORD_W-1:0]            spr_wr_x;
  logic [COORD_W-1:0]            spr_wr_y;
  logic [SIZE_W-1:0]             spr_wr_w;
  logic [SIZE_W-1:0]             spr_wr_h;
  logic [1:0]                    spr_wr_scale;
  logic                          spr_wr_enable;
  logic                          pal_wr_en;
  logic [PIX_W-1:0]              pal_wr_idx;
  logic [23:0]                   pal_wr_rgb;
  logic [23:0]                   bg_rgb;
  logic [NUM_SPRITES*ADDR_W-1:0] rom_addr;
  logic [NUM_SPRITES*PIX_W-1:0]  rom_data;
  logic [7:0]                    red;
  logic [7:0]                    green;
  logic [7:0]                    blue;
  logic [NUM_SPRITES-1:0]        collision;

  modport master (
    output draw_x, draw_y, blank, frame_start,
    output spr_wr_en, spr_wr_sel, spr_wr_x, spr_wr_y, spr_wr_w, spr_wr_h,
    output spr_wr_scale, spr_wr_enable,
    output pal_wr_en, pal_wr_idx, pal_wr_rgb, bg_rgb, rom_data,
    input  rom_addr, red, green, blue, collision
  );

  modport slave (
    input  draw_x, draw_y, blank, frame_start,
    input  spr_wr_en, spr_wr_sel, spr_wr_x, spr_wr_y, spr_wr_w, spr_wr_h,
    input  spr_wr_scale, spr_wr_enable,
    input  pal_wr_en, pal_wr_idx, pal_wr_rgb, bg_rgb, rom_data,
    output rom_addr, red, green, blue, collision
  );
endinterface

// File: rtl/sprite_compositor.sv
// sprite_compositor
// Composites NUM_SPRITES scaled, colour-keyed sprites over a background, one
// pixel per clock, three register stages from pixel input to RGB:
//   S1: per-sprite hit test and ROM address        (registered, drives rom_addr)
//   S2: ROM data -> opaque mask -> priority winner (registered)
//   S3: blanking / palette / background select     (registered RGB)
// Sprite attributes are written to a shadow bank and committed to the active
// bank on frame_start. Sprite-0 overlaps are accumulated per frame.
// Ports: clk, rst (async, active-high), bus (sprite_compositor_if.slave).
module sprite_compositor #(
  parameter int NUM_SPRITES = 4,
  parameter int COORD_W     = 10,
  parameter int PIX_W       = 3,
  parameter int ADDR_W      = 13,
  parameter int SIZE_W      = 7,
  parameter int TRANSP_IDX  = 1
) (
  input logic                clk,
  input logic                rst,
  sprite_compositor_if.slave bus
);
  // Four guard bits so x + (w << 3) never wraps past the screen edge.
  localparam int CW    = COORD_W + 4;
  localparam int LW    = CW + SIZE_W;
  localparam int SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int PAL_N = 2 ** PIX_W;

  typedef struct packed {
    logic               en;
    logic [1:0]         scale;
    logic [SIZE_W-1:0]  w;
    logic [SIZE_W-1:0]  h;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } attr_t;

  attr_t shadow_q [NUM_SPRITES];
  attr_t active_q [NUM_SPRITES];

  // NOTE: clocked blocks use non-blocking (<=) so every register samples
  // pre-edge values; that is also why a commit coinciding with a shadow write
  // picks up the old shadow contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_SPRITES; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_SPRITES; k++) begin
        if (bus.frame_start)
          active_q[k] <= shadow_q[k];
        if (bus.spr_wr_en && bus.spr_wr_sel == SEL_W'(k))
          shadow_q[k] <= '{en: bus.spr_wr_enable, scale: bus.spr_wr_scale,
                           w: bus.spr_wr_w, h: bus.spr_wr_h,
                           x: bus.spr_wr_x, y: bus.spr_wr_y};
      end
    end
  end

  function automatic logic [23:0] pal_default(input int i);
    case (i)
      0:       return 24'h00FF44;
      1:       return 24'hFFDDEE;
      2:       return 24'hCC7711;
      3:       return 24'hDD00FF;
      4:       return 24'h662255;
      5:       return 24'h662266;
      6:       return 24'h000000;
      7:       return 24'hAAAAAA;
      default: return 24'h000000;
    endcase
  endfunction

  logic [23:0] pal_q [PAL_N];

  // NOTE: the palette is a small register file with defined power-on colours,
  // so it is reset like any other register; a large RAM would not be.
  // The index is PIX_W bits wide, so out-of-range writes cannot occur.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PAL_N; i++) pal_q[i] <= pal_default(i);
    end else if (bus.pal_wr_en) begin
      pal_q[bus.pal_wr_idx] <= bus.pal_wr_rgb;
    end
  end

  // ---------------- S1: hit test and ROM address ----------------
  logic [NUM_SPRITES-1:0] hit_c;
  logic [ADDR_W-1:0]      addr_c [NUM_SPRITES];

  // NOTE: every variable written in always_comb is given a value before any
  // conditional logic, so no path can infer a latch.
  always_comb begin
    logic [CW-1:0] px, py, sx, sy, span_x, span_y, rel_x, rel_y;
    logic [LW-1:0] lin;
    hit_c = '0;
    for (int k = 0; k < NUM_SPRITES; k++) begin
      addr_c[k] = '0;
      px     = CW'(bus.draw_x);
      py     = CW'(bus.draw_y);
      sx     = CW'(active_q[k].x);
      sy     = CW'(active_q[k].y);
      span_x = CW'(active_q[k].w) << active_q[k].scale;
      span_y = CW'(active_q[k].h) << active_q[k].scale;
      // A zero width or height gives an empty span, so it never hits.
      hit_c[k] = active_q[k].en && (px >= sx) && (px < sx + span_x)
                 && (py >= sy) && (py < sy + span_y);
      rel_x = (px - sx) >> active_q[k].scale;
      rel_y = (py - sy) >> active_q[k].scale;
      lin   = LW'(rel_y) * LW'(active_q[k].w) + LW'(rel_x);
      if (hit_c[k]) addr_c[k] = ADDR_W'(lin);
    end
  end

  logic [NUM_SPRITES*ADDR_W-1:0] rom_addr_q;
  logic [NUM_SPRITES-1:0]        s1_hit_q;
  logic                          s1_blank_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr_q <= '0;
      s1_hit_q   <= '0;
      s1_blank_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_SPRITES; k++)
        rom_addr_q[k*ADDR_W +: ADDR_W] <= addr_c[k];
      s1_hit_q   <= hit_c;
      s1_blank_q <= bus.blank;
    end
  end

  assign bus.rom_addr = rom_addr_q;

  // ---------------- S2: opaque mask, priority winner, collisions ----------------
  logic [NUM_SPRITES-1:0] opaque_c;
  logic [NUM_SPRITES-1:0] coll_new_c;
  logic                   win_found_c;
  logic [PIX_W-1:0]       win_idx_c;

  always_comb begin
    opaque_c    = '0;
    win_found_c = 1'b0;
    win_idx_c   = '0;
    for (int k = 0; k < NUM_SPRITES; k++)
      opaque_c[k] = s1_hit_q[k]
                    && (bus.rom_data[k*PIX_W +: PIX_W] != PIX_W'(TRANSP_IDX));
    // Walk from lowest priority upwards so sprite 0 overwrites last and wins.
    for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
      if (opaque_c[k]) begin
        win_found_c = 1'b1;
        win_idx_c   = bus.rom_data[k*PIX_W +: PIX_W];
      end
    end
    coll_new_c = (s1_blank_q && opaque_c[0]) ? (opaque_c & ~NUM_SPRITES'(1)) : '0;
  end

  logic                   s2_found_q;
  logic [PIX_W-1:0]       s2_idx_q;
  logic                   s2_blank_q;
  logic [NUM_SPRITES-1:0] work_q;
  logic [NUM_SPRITES-1:0] collision_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_found_q  <= 1'b0;
      s2_idx_q    <= '0;
      s2_blank_q  <= 1'b0;
      work_q      <= '0;
      collision_q <= '0;
    end else begin
      s2_found_q <= win_found_c;
      s2_idx_q   <= win_idx_c;
      s2_blank_q <= s1_blank_q;
      // An overlap seen on the frame_start cycle belongs to the new frame.
      if (bus.frame_start) begin
        collision_q <= work_q;
        work_q      <= coll_new_c;
      end else begin
        work_q <= work_q | coll_new_c;
      end
    end
  end

  assign bus.collision = collision_q;

  // ---------------- S3: colour select ----------------
  logic [23:0] rgb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rgb_q <= '0;
    else if (!s2_blank_q)
      rgb_q <= '0;
    else if (s2_found_q)
      rgb_q <= pal_q[s2_idx_q];
    else
      rgb_q <= bus.bg_rgb;
  end

  assign bus.red   = rgb_q[23:16];
  assign bus.green = rgb_q[15:8];
  assign bus.blue  = rgb_q[7:0];
endmodule

// File: tb/tb_sprite_compositor.sv
module tb_sprite_compositor;
  localparam int NS = 4;
  localparam int CW = 10;
  localparam int PW = 3;
  localparam int AW = 13;
  localparam int SW = 7;
  localparam int TR = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sprite_compositor_if #(.NUM_SPRITES(NS), .COORD_W(CW), .PIX_W(PW),
                         .ADDR_W(AW), .SIZE_W(SW)) bus ();

  sprite_compositor #(.NUM_SPRITES(NS), .COORD_W(CW), .PIX_W(PW), .ADDR_W(AW),
                      .SIZE_W(SW), .TRANSP_IDX(TR)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Sprite ROMs: asynchronous read of the registered address.
  logic [PW-1:0] rom_mem [NS][2**AW];
  always_comb begin
    bus.rom_data = '0;
    for (int k = 0; k < NS; k++)
      bus.rom_data[k*PW +: PW] = rom_mem[k][bus.rom_addr[k*AW +: AW]];
  end

  // ---------------- reference model ----------------
  typedef struct {
    int x; int y; int w; int h; int s; bit en;
  } spr_t;

  spr_t        m_shadow [NS];
  spr_t        m_active [NS];
  logic [23:0] m_pal [8];
  logic [23:0] bg;
  int          m_coll, m_work, coll_pipe;
  int          m_addr [NS];
  int          prev_addr [NS];
  bit          have_prev;
  logic [23:0] exp_q [$];

  // pending one-cycle writes applied by the next step
  bit          p_wr;
  int          p_sel;
  spr_t        p_spr;
  bit          p_pal;
  int          p_pal_idx;
  logic [23:0] p_pal_rgb;

  int total = 0;
  int bad   = 0;

  task automatic model_reset();
    for (int k = 0; k < NS; k++) begin
      m_shadow[k] = '{x: 0, y: 0, w: 0, h: 0, s: 0, en: 1'b0};
      m_active[k] = m_shadow[k];
    end
    m_pal = '{24'h00FF44, 24'hFFDDEE, 24'hCC7711, 24'hDD00FF,
              24'h662255, 24'h662266, 24'h000000, 24'hAAAAAA};
    m_coll = 0; m_work = 0; coll_pipe = 0;
    have_prev = 1'b0;
    exp_q.delete();
  endtask

  // Spec-level evaluation of one pixel against the active attributes.
  task automatic model_pixel(input int x, input int y, input bit blank,
                             output logic [23:0] rgb, output int contrib);
    int win;
    bit opq [NS];
    win = -1;
    contrib = 0;
    for (int k = 0; k < NS; k++) begin
      int sc;
      sc = 1 << m_active[k].s;
      m_addr[k] = 0;
      opq[k] = 1'b0;
      if (m_active[k].en && x >= m_active[k].x && x < m_active[k].x + m_active[k].w * sc
          && y >= m_active[k].y && y < m_active[k].y + m_active[k].h * sc) begin
        m_addr[k] = (((y - m_active[k].y) / sc) * m_active[k].w
                     + (x - m_active[k].x) / sc) % (2**AW);
        if (int'(rom_mem[k][m_addr[k]]) != TR) begin
          opq[k] = 1'b1;
          if (win < 0) win = k;
        end
      end
    end
    if (!blank)       rgb = 24'h0;
    else if (win >= 0) rgb = m_pal[rom_mem[win][m_addr[win]]];
    else              rgb = bg;
    if (blank && opq[0])
      for (int k = 1; k < NS; k++) if (opq[k]) contrib |= (1 << k);
  endtask

  // One pixel clock: check outputs of earlier pixels, drive a new one, advance the model.
  task automatic step(input int x, input int y, input bit blank, input bit fs);
    logic [23:0] e, got;
    int contrib;
    @(negedge clk);
    if (exp_q.size() == 3) begin
      e   = exp_q.pop_front();
      got = {bus.red, bus.green, bus.blue};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL rgb t=%0t got=%06h want=%06h", $time, got, e);
      end
    end
    if (have_prev) begin
      for (int k = 0; k < NS; k++) begin
        total++;
        if (bus.rom_addr[k*AW +: AW] !== AW'(prev_addr[k])) begin
          bad++;
          $display("FAIL rom_addr%0d t=%0t got=%0d want=%0d", k, $time,
                   bus.rom_addr[k*AW +: AW], prev_addr[k]);
        end
      end
    end
    total++;
    if (bus.collision !== NS'(m_coll)) begin
      bad++;
      $display("FAIL collision t=%0t got=%b want=%b", $time, bus.collision, NS'(m_coll));
    end
    bus.draw_x        = CW'(x);
    bus.draw_y        = CW'(y);
    bus.blank         = blank;
    bus.frame_start   = fs;
    bus.bg_rgb        = bg;
    bus.spr_wr_en     = p_wr;
    bus.spr_wr_sel    = 2'(p_sel);
    bus.spr_wr_x      = CW'(p_spr.x);
    bus.spr_wr_y      = CW'(p_spr.y);
    bus.spr_wr_w      = SW'(p_spr.w);
    bus.spr_wr_h      = SW'(p_spr.h);
    bus.spr_wr_scale  = 2'(p_spr.s);
    bus.spr_wr_enable = p_spr.en;
    bus.pal_wr_en     = p_pal;
    bus.pal_wr_idx    = PW'(p_pal_idx);
    bus.pal_wr_rgb    = p_pal_rgb;
    model_pixel(x, y, blank, e, contrib);
    exp_q.push_back(e);
    prev_addr = m_addr;
    have_prev = 1'b1;
    if (fs) begin
      m_coll = m_work;
      m_work = coll_pipe;
    end else begin
      m_work |= coll_pipe;
    end
    coll_pipe = contrib;
    if (fs) m_active = m_shadow;
    if (p_wr) m_shadow[p_sel] = p_spr;
    if (p_pal) m_pal[p_pal_idx] = p_pal_rgb;
    p_wr  = 1'b0;
    p_pal = 1'b0;
  endtask

  // Blanked pixels: nothing in flight depends on ROM, palette or background afterwards.
  task automatic flush();
    repeat (3) step(0, 0, 1'b0, 1'b0);
  endtask

  task automatic set_spr(input int sel, input int x, input int y, input int w,
                         input int h, input int s, input bit en, input bit fs);
    p_wr  = 1'b1;
    p_sel = sel;
    p_spr = '{x: x, y: y, w: w, h: h, s: s, en: en};
    step(0, 0, 1'b0, fs);
  endtask

  task automatic fill_rom(input int k, input int val);
    for (int a = 0; a < 2**AW; a++)
      rom_mem[k][a] = (val < 0) ? PW'($urandom_range(0, 2**PW - 1)) : PW'(val);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [23:0] got;
    rst = 1'b1;
    #3;
    got = {bus.red, bus.green, bus.blue};
    total++;
    if (got !== 24'h0) begin bad++; $display("FAIL reset_rgb got=%06h want=000000", got); end
    total++;
    if (bus.collision !== '0) begin bad++; $display("FAIL reset_collision got=%b want=0", bus.collision); end
    total++;
    if (bus.rom_addr !== '0) begin bad++; $display("FAIL reset_rom_addr got=%h want=0", bus.rom_addr); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    bg = 24'($urandom);
    for (int i = 0; i < 40; i++)
      step($urandom_range(0, 1023), $urandom_range(0, 1023), 1'b1, (i == 20));
    flush();
  endtask

  task automatic test_sprite0_bounds();
    logic [23:0] got;
    fill_rom(0, -1);
    rom_mem[0][0] = 3'd3;
    set_spr(0, 300, 380, 50, 100, 0, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b1);
    step(300, 380, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    total++;
    if (bus.rom_addr[0 +: AW] !== AW'(0)) begin
      bad++; $display("FAIL s0_first_addr got=%0d want=0", bus.rom_addr[0 +: AW]);
    end
    step(0, 0, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    got = {bus.red, bus.green, bus.blue};
    total++;
    if (got !== 24'hDD00FF) begin bad++; $display("FAIL s0_first_rgb got=%06h want=DD00FF", got); end
    step(349, 479, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    total++;
    if (bus.rom_addr[0 +: AW] !== AW'(4999)) begin
      bad++; $display("FAIL s0_last_addr got=%0d want=4999", bus.rom_addr[0 +: AW]);
    end
    step(350, 380, 1'b1, 1'b0);
    flush();
    got = {bus.red, bus.green, bus.blue};
    total++;
    if (got !== bg) begin bad++; $display("FAIL s0_right_edge got=%06h want=%06h", got, bg); end
  endtask

  task automatic test_scaled();
    logic [23:0] got;
    fill_rom(1, -1);
    rom_mem[1][1] = 3'd4;
    set_spr(1, 20, 20, 8, 16, 2, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b1);
    step(27, 23, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    total++;
    if (bus.rom_addr[AW +: AW] !== AW'(1)) begin
      bad++; $display("FAIL scaled_addr got=%0d want=1", bus.rom_addr[AW +: AW]);
    end
    step(0, 0, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    got = {bus.red, bus.green, bus.blue};
    total++;
    if (got !== 24'h662255) begin bad++; $display("FAIL scaled_rgb got=%06h want=662255", got); end
    step(51, 83, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    total++;
    if (bus.rom_addr[AW +: AW] !== AW'(127)) begin
      bad++; $display("FAIL scaled_corner got=%0d want=127", bus.rom_addr[AW +: AW]);
    end
    step(52, 20, 1'b1, 1'b0);
    step(53, 21, 1'b1, 1'b0);
    total++;
    if (bus.rom_addr[AW +: AW] !== AW'(0)) begin
      bad++; $display("FAIL scaled_miss got=%0d want=0", bus.rom_addr[AW +: AW]);
    end
    flush();
  endtask

  task automatic test_overlap_collision();
    logic [23:0] got;
    fill_rom(0, 2);
    fill_rom(2, 3);
    set_spr(2, 290, 370, 20, 20, 0, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b1);
    step(305, 385, 1'b1, 1'b0);
    flush();
    got = {bus.red, bus.green, bus.blue};
    total++;
    if (got !== 24'hCC7711) begin bad++; $display("FAIL overlap_rgb got=%06h want=CC7711", got); end
    fill_rom(0, TR);
    step(305, 385, 1'b1, 1'b0);
    flush();
    got = {bus.red, bus.green, bus.blue};
    total++;
    if (got !== 24'hDD00FF) begin bad++; $display("FAIL transparent_rgb got=%06h want=DD00FF", got); end
    step(0, 0, 1'b0, 1'b1);
    step(0, 0, 1'b0, 1'b0);
    total++;
    if (bus.collision !== 4'b0100) begin
      bad++; $display("FAIL collision_frame got=%b want=0100", bus.collision);
    end
  endtask

  task automatic test_commit_race();
    fill_rom(3, -1);
    set_spr(3, 600, 100, 10, 10, 0, 1'b1, 1'b1);
    step(0, 0, 1'b0, 1'b1);
    set_spr(3, 700, 100, 10, 10, 0, 1'b1, 1'b1);
    step(701, 100, 1'b1, 1'b0);
    step(601, 100, 1'b1, 1'b0);
    total++;
    if (bus.rom_addr[3*AW +: AW] !== AW'(0)) begin
      bad++; $display("FAIL race_new_early got=%0d want=0", bus.rom_addr[3*AW +: AW]);
    end
    step(0, 0, 1'b0, 1'b0);
    total++;
    if (bus.rom_addr[3*AW +: AW] !== AW'(1)) begin
      bad++; $display("FAIL race_old_kept got=%0d want=1", bus.rom_addr[3*AW +: AW]);
    end
    step(0, 0, 1'b0, 1'b1);
    step(701, 100, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    total++;
    if (bus.rom_addr[3*AW +: AW] !== AW'(1)) begin
      bad++; $display("FAIL race_new_late got=%0d want=1", bus.rom_addr[3*AW +: AW]);
    end
    flush();
  endtask

  task automatic test_blank_palette();
    logic [23:0] got;
    fill_rom(2, 2);
    step(292, 372, 1'b0, 1'b0);
    flush();
    got = {bus.red, bus.green, bus.blue};
    total++;
    if (got !== 24'h0) begin bad++; $display("FAIL blank_rgb got=%06h want=000000", got); end
    p_pal = 1'b1; p_pal_idx = 2; p_pal_rgb = 24'h123456;
    step(0, 0, 1'b0, 1'b0);
    step(292, 372, 1'b1, 1'b0);
    flush();
    total++;
    if (bus.red !== 8'h12) begin bad++; $display("FAIL pal_red got=%02h want=12", bus.red); end
    total++;
    if (bus.green !== 8'h34) begin bad++; $display("FAIL pal_green got=%02h want=34", bus.green); end
    total++;
    if (bus.blue !== 8'h56) begin bad++; $display("FAIL pal_blue got=%02h want=56", bus.blue); end
  endtask

  function automatic int rand_coord(input bit edge_zone);
    return edge_zone ? int'($urandom_range(980, 1023)) : int'($urandom_range(0, 200));
  endfunction

  task automatic test_random();
    for (int k = 0; k < NS; k++) fill_rom(k, -1);
    for (int k = 0; k < NS; k++)
      set_spr(k, rand_coord($urandom_range(0, 3) == 0), rand_coord($urandom_range(0, 3) == 0),
              $urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 3),
              $urandom_range(0, 4) != 0, 1'b0);
    step(0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 1500; i++) begin
      bit ez;
      ez = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) begin
        p_wr  = 1'b1;
        p_sel = $urandom_range(0, NS - 1);
        p_spr = '{x: rand_coord(ez), y: rand_coord(ez), w: $urandom_range(0, 20),
                  h: $urandom_range(0, 20), s: $urandom_range(0, 3),
                  en: ($urandom_range(0, 4) != 0)};
      end
      step(rand_coord(ez), rand_coord(ez), $urandom_range(0, 7) != 0,
           $urandom_range(0, 39) == 0);
    end
    flush();
  endtask

  task automatic test_reset_midline();
    logic [23:0] got;
    set_spr(0, 300, 380, 50, 100, 0, 1'b1, 1'b1);
    step(0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(300 + i, 390, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    got = {bus.red, bus.green, bus.blue};
    total++;
    if (got !== 24'h0) begin bad++; $display("FAIL midline_rgb got=%06h want=000000", got); end
    total++;
    if (bus.collision !== '0) begin bad++; $display("FAIL midline_collision got=%b want=0", bus.collision); end
    total++;
    if (bus.rom_addr !== '0) begin bad++; $display("FAIL midline_rom_addr got=%h want=0", bus.rom_addr); end
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) step(300 + i, 390, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(300 + i, 390, 1'b1, 1'b0);
    set_spr(0, 300, 380, 50, 100, 0, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(300 + i, 390, 1'b1, 1'b0);
    flush();
  endtask

  initial begin
    rst = 1'b1;
    bus.draw_x = '0; bus.draw_y = '0; bus.blank = 1'b0; bus.frame_start = 1'b0;
    bus.spr_wr_en = 1'b0; bus.spr_wr_sel = '0; bus.spr_wr_x = '0; bus.spr_wr_y = '0;
    bus.spr_wr_w = '0; bus.spr_wr_h = '0; bus.spr_wr_scale = '0; bus.spr_wr_enable = 1'b0;
    bus.pal_wr_en = 1'b0; bus.pal_wr_idx = '0; bus.pal_wr_rgb = '0; bus.bg_rgb = '0;
    p_wr = 1'b0; p_sel = 0; p_spr = '{x: 0, y: 0, w: 0, h: 0, s: 0, en: 1'b0};
    p_pal = 1'b0; p_pal_idx = 0; p_pal_rgb = '0;
    bg = '0;
    for (int k = 0; k < NS; k++) fill_rom(k, -1);
    model_reset();

    test_reset();
    test_sprite0_bounds();
    test_scaled();
    test_overlap_collision();
    test_commit_race();
    test_blank_palette();
    test_random();
    test_reset_midline();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
